// File: rtl/expr_gen.sv
// rtl/expr_gen.sv - BCD expression to ASCII serialiser; optional '=' terminator under EXPR_GEN_TERM_EN
module expr_gen #(
    parameter int MAX_TERMS = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       start,
    input  logic [3:0]                 nterms,
    input  logic [4*MAX_TERMS-1:0]     digits,
    input  logic [2*(MAX_TERMS-1)-1:0] ops,
    input  logic                       hold,
    output logic [7:0]                 out_char,
    output logic                       out_vld,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int IDXW = $clog2(MAX_TERMS);

    typedef enum logic [2:0] {
        IDLE,
        DIGIT,
        OP,
`ifdef EXPR_GEN_TERM_EN
        TERM,
`endif
        FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [3:0]             nterms_q, nterms_d;
    logic [4*MAX_TERMS-1:0] digits_q, digits_d;
    // One spare operator slot so the select stays in range when idx points at the last operand
    logic [2*MAX_TERMS-1:0] ops_q, ops_d;
    logic [7:0]             char_q, char_d;
    logic                   vld_q, vld_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   req_ok;
    logic                   last_digit;
    logic [3:0]             cur_digit;
    logic [1:0]             cur_op;
    logic [7:0]             op_char;

    assign cur_digit  = digits_q[{idx_q, 2'b00} +: 4];
    assign cur_op     = ops_q[{idx_q, 1'b0} +: 2];
    assign last_digit = (4'(idx_q) == (nterms_q - 4'd1));

    // Request check: operand count in range and every used operand a BCD digit
    always_comb begin
        req_ok = (nterms != 4'd0) && (int'(nterms) <= MAX_TERMS);
        for (int k = 0; k < MAX_TERMS; k++) begin
            if ((k < int'(nterms)) && (digits[4*k +: 4] > 4'd9)) begin
                req_ok = 1'b0;
            end
        end
    end

    // Operator code to ASCII
    always_comb begin
        case (cur_op)
            2'b00:   op_char = 8'h2B;
            2'b01:   op_char = 8'h2D;
            2'b10:   op_char = 8'h2A;
            default: op_char = 8'h2F;
        endcase
    end

    // Next-state and registered-output logic; hold freezes everything except the valid flag
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nterms_d = nterms_q;
        digits_d = digits_q;
        ops_d    = ops_q;
        char_d   = char_q;
        vld_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    // Cycle showing the done pulse: busy still high, start not sampled
                    busy_d = 1'b0;
                end else if (start) begin
                    if (req_ok) begin
                        nterms_d = nterms;
                        digits_d = digits;
                        ops_d    = {2'b00, ops};
                        idx_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = DIGIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DIGIT: begin
                if (!hold) begin
                    char_d = 8'h30 + {4'h0, cur_digit};
                    vld_d  = 1'b1;
                    if (!last_digit) begin
                        state_d = OP;
                    end else begin
`ifdef EXPR_GEN_TERM_EN
                        state_d = TERM;
`else
                        state_d = FIN;
`endif
                    end
                end
            end
            OP: begin
                if (!hold) begin
                    char_d  = op_char;
                    vld_d   = 1'b1;
                    idx_d   = idx_q + IDXW'(1);
                    state_d = DIGIT;
                end
            end
`ifdef EXPR_GEN_TERM_EN
            TERM: begin
                if (!hold) begin
                    char_d  = 8'h3D;
                    vld_d   = 1'b1;
                    state_d = FIN;
                end
            end
`endif
            FIN: begin
                if (!hold) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            nterms_q <= 4'd0;
            digits_q <= '0;
            ops_q    <= '0;
            char_q   <= 8'h00;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nterms_q <= nterms_d;
            digits_q <= digits_d;
            ops_q    <= ops_d;
            char_q   <= char_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out_char = char_q;
    assign out_vld  = vld_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_expr_gen.sv
// tb/tb_expr_gen.sv - Self-checking bench for expr_gen with a character scoreboard
module tb_expr_gen;

    logic        clk;
    logic        clr;
    logic        start;
    logic [3:0]  nterms;
    logic [15:0] digits;
    logic [5:0]  ops;
    logic        hold;
    logic [7:0]  out_char;
    logic        out_vld;
    logic        busy;
    logic        done;
    logic        err;

    expr_gen #(.MAX_TERMS(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .nterms   (nterms),
        .digits   (digits),
        .ops      (ops),
        .hold     (hold),
        .out_char (out_char),
        .out_vld  (out_vld),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        logic [3:0]  nt;
        logic [15:0] dg;
        logic [5:0]  op;
        bit          bad;
        string       s;
    } vec_t;

    vec_t       vecs[10];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         mon_en = 0;
    int         vld_n = 0;
    int         first_vld = 0;
    int         last_vld = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard consumer: every valid character must match the head of the expected queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_char", {24'h0, out_char}, 32'h0);
                end else begin
                    chk("char", {24'h0, out_char}, {24'h0, exp_q.pop_front()});
                end
                if (vld_n == 0) first_vld = cyc;
                last_vld = cyc;
                vld_n++;
            end
            if (done) begin
                chk("done_busy", {31'h0, busy}, 32'h1);
                chk("done_vld", {31'h0, out_vld}, 32'h0);
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int elen(input string s);
`ifdef EXPR_GEN_TERM_EN
        return s.len() + 1;
`else
        return s.len();
`endif
    endfunction

    task automatic push_str(input string s, input bit term);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (term) begin
`ifdef EXPR_GEN_TERM_EN
            exp_q.push_back(8'h3D);
`endif
        end
    endtask

    // One-cycle start; inputs are scrambled afterwards so only captured copies can matter
    task automatic issue(input logic [3:0] nt, input logic [15:0] dg, input logic [5:0] op,
                         input string s, input bit term, output int a);
        push_str(s, term);
        vld_n  = 0;
        start  = 1'b1;
        nterms = nt;
        digits = dg;
        ops    = op;
        a      = cyc;
        tick();
        start  = 1'b0;
        nterms = 4'($urandom);
        digits = 16'($urandom);
        ops    = 6'($urandom);
    endtask

    task automatic wait_done(input int a, input int len, input bit timing);
        int base;
        int k;
        base = done_cnt;
        k = 0;
        while (done_cnt == base && k < 200) begin
            tick();
            k++;
        end
        chk("done_seen", done_cnt - base, 1);
        if (done_cnt != base) begin
            chk("chars_left", exp_q.size(), 0);
            chk("vld_count", vld_n, len);
            if (timing) begin
                chk("first_latency", first_vld - a, 2);
                chk("contiguous", last_vld - first_vld + 1, len);
            end
            chk("done_after_last", done_cyc - last_vld, 1);
            tick();
            chk("busy_after_done", {31'h0, busy}, 32'h0);
            chk("done_single", {31'h0, done}, 32'h0);
        end
    endtask

    initial begin
        int a;
        int base;
        int k;
        int d_a;

        // digits[4k+3:4k] is operand k; ops[2k+1:2k] is op k (00 + 01 - 10 * 11 /)
        vecs[0] = '{4'd4, 16'h4321, 6'b001000, 1'b0, "1+2*3+4"};
        vecs[1] = '{4'd2, 16'h0090, 6'b000011, 1'b0, "0/9"};
        vecs[2] = '{4'd1, 16'hFFF5, 6'b111111, 1'b0, "5"};
        vecs[3] = '{4'd3, 16'h0381, 6'b001101, 1'b0, "1-8/3"};
        vecs[4] = '{4'd4, 16'h9999, 6'b010101, 1'b0, "9-9-9-9"};
        vecs[5] = '{4'd0, 16'h1111, 6'b000000, 1'b1, ""};
        vecs[6] = '{4'd5, 16'h1111, 6'b000000, 1'b1, ""};
        vecs[7] = '{4'd2, 16'h00A1, 6'b000000, 1'b1, ""};
        vecs[8] = '{4'd4, 16'hF111, 6'b000000, 1'b1, ""};
        vecs[9] = '{4'd15, 16'h1111, 6'b000000, 1'b1, ""};

        // Reset wins over start and hold
        clr    = 1'b0;
        start  = 1'b1;
        hold   = 1'b1;
        nterms = 4'd4;
        digits = 16'h4321;
        ops    = 6'b0;
        repeat (3) tick();
        chk("rst_char", {24'h0, out_char}, 32'h0);
        chk("rst_vld", {31'h0, out_vld}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        clr    = 1'b1;
        start  = 1'b0;
        hold   = 1'b0;
        mon_en = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].bad) begin
                issue(vecs[i].nt, vecs[i].dg, vecs[i].op, "", 1'b0, a);
                chk("err_pulse", {31'h0, err}, 32'h1);
                chk("err_busy", {31'h0, busy}, 32'h0);
                tick();
                chk("err_single", {31'h0, err}, 32'h0);
                tick();
                chk("err_idle_busy", {31'h0, busy}, 32'h0);
            end else begin
                issue(vecs[i].nt, vecs[i].dg, vecs[i].op, vecs[i].s, 1'b1, a);
                wait_done(a, elen(vecs[i].s), 1'b1);
            end
        end

        // Hold for two cycles while '2' is pending
        issue(4'd3, 16'h0321, 6'b000000, "1+2+3", 1'b1, a);
        tick();
        tick();
        hold = 1'b1;
        tick();
        chk("hold_vld_1", {31'h0, out_vld}, 32'h0);
        chk("hold_char_1", {24'h0, out_char}, 32'h2B);
        tick();
        chk("hold_vld_2", {31'h0, out_vld}, 32'h0);
        chk("hold_char_2", {24'h0, out_char}, 32'h2B);
        hold = 1'b0;
        wait_done(a, elen("1+2+3"), 1'b0);

        // Reset after "1+" aborts the expression
        issue(4'd4, 16'h4321, 6'b001000, "1+", 1'b0, a);
        tick();
        tick();
        clr = 1'b0;
        tick();
        chk("abort_char", {24'h0, out_char}, 32'h0);
        chk("abort_vld", {31'h0, out_vld}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_err", {31'h0, err}, 32'h0);
        chk("abort_chars_seen", exp_q.size(), 0);
        clr  = 1'b1;
        base = done_cnt;
        repeat (6) tick();
        chk("abort_no_done", done_cnt - base, 0);
        issue(4'd1, 16'h0007, 6'b000000, "7", 1'b1, a);
        wait_done(a, elen("7"), 1'b1);

        // start held high across two requests: two idle cycles between done and next character
        push_str("3-4", 1'b1);
        push_str("5/6", 1'b1);
        vld_n  = 0;
        start  = 1'b1;
        nterms = 4'd2;
        digits = 16'h0043;
        ops    = 6'b000001;
        tick();
        digits = 16'h0065;
        ops    = 6'b000011;
        base   = done_cnt;
        k      = 0;
        while (done_cnt == base && k < 200) begin
            tick();
            k++;
        end
        chk("b2b_first_done", done_cnt - base, 1);
        d_a   = done_cyc;
        vld_n = 0;
        k     = 0;
        while (done_cnt < base + 2 && k < 200) begin
            tick();
            k++;
        end
        start = 1'b0;
        chk("b2b_second_done", done_cnt - base, 2);
        chk("b2b_gap", first_vld - d_a, 3);
        chk("b2b_vld_count", vld_n, elen("5/6"));
        chk("b2b_chars_left", exp_q.size(), 0);
        tick();
        chk("b2b_busy_after", {31'h0, busy}, 32'h0);
        tick();
        chk("b2b_no_restart", {31'h0, busy}, 32'h0);

        repeat (3) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
